// File: rtl/rle_pkg.sv
// Shared definitions for the RLE fetch arbiter: channel count, channel
// indices, FSM state encoding and a one-hot to index helper.
package rle_pkg;

  localparam int N_CH = 3;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH_R = 2'd0;
  localparam ch_idx_t CH_G = 2'd1;
  localparam ch_idx_t CH_B = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Convert a one-hot 3-bit grant into a channel index (R for all-zero).
  function automatic ch_idx_t onehot_to_idx(input logic [2:0] oh);
    ch_idx_t idx;
    case (oh)
      3'b010:  idx = CH_G;
      3'b100:  idx = CH_B;
      default: idx = CH_R;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rle_fetch_arbiter_if.sv
// Bundle of the configuration, channel request and memory port signals of
// the fetch arbiter. The arbiter uses the slave view; its environment
// (decoders plus memory) uses the master view.
interface rle_fetch_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  logic              start;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] base_g;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] len_g;
  logic [ADDR_W-1:0] len_b;
  logic [2:0]        req;
  logic [2:0]        gnt;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] rdata;
  logic [2:0]        rvalid;
  logic [2:0]        eos;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_r, base_g, base_b, len_r, len_g, len_b, req, mem_data,
    output gnt, mem_rd, mem_addr, rdata, rvalid, eos, busy, done
  );

  modport master (
    output start, base_r, base_g, base_b, len_r, len_g, len_b, req, mem_data,
    input  gnt, mem_rd, mem_addr, rdata, rvalid, eos, busy, done
  );

endinterface

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin picker: grants the first eligible channel
// found when searching cyclically from the channel after the last winner.
module rr_arb3
  import rle_pkg::*;
(
  input  logic [2:0] eligible,
  input  ch_idx_t    last,
  output logic [2:0] gnt
);

  // Priority order rotates so the previous winner is searched last.
  always_comb begin
    gnt = 3'b000;
    case (last)
      CH_R: begin
        if (eligible[1])      gnt = 3'b010;
        else if (eligible[2]) gnt = 3'b100;
        else if (eligible[0]) gnt = 3'b001;
        else                  gnt = 3'b000;
      end
      CH_G: begin
        if (eligible[2])      gnt = 3'b100;
        else if (eligible[0]) gnt = 3'b001;
        else if (eligible[1]) gnt = 3'b010;
        else                  gnt = 3'b000;
      end
      default: begin
        if (eligible[0])      gnt = 3'b001;
        else if (eligible[1]) gnt = 3'b010;
        else if (eligible[2]) gnt = 3'b100;
        else                  gnt = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/rle_fetch_arbiter.sv
// Shares one synchronous encoded-data memory read port among the R, G and B
// RLE channel decoders. Each channel walks its own byte region; one byte per
// cycle is granted round-robin and the read data is steered back one cycle
// later via rvalid.
module rle_fetch_arbiter
  import rle_pkg::*;
#(
  parameter int ADDR_W = 16
)(
  input  logic               clk,
  input  logic               rst,
  rle_fetch_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q [N_CH];
  logic [ADDR_W-1:0] ptr_d [N_CH];
  logic [ADDR_W-1:0] rem_q [N_CH];
  logic [ADDR_W-1:0] rem_d [N_CH];
  logic [2:0]        eos_q, eos_d;
  logic [2:0]        rvalid_q, rvalid_d;
  ch_idx_t           last_q, last_d;
  logic              done_q, done_d;

  logic [2:0]        elig_s;
  logic [2:0]        gnt_s;
  ch_idx_t           gidx_s;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0] base_s [N_CH];
  logic [ADDR_W-1:0] len_s  [N_CH];

  assign base_s[CH_R] = bus.base_r;
  assign base_s[CH_G] = bus.base_g;
  assign base_s[CH_B] = bus.base_b;
  assign len_s[CH_R]  = bus.len_r;
  assign len_s[CH_G]  = bus.len_g;
  assign len_s[CH_B]  = bus.len_b;

  // A channel may compete only while running and with bytes left.
  always_comb begin
    elig_s = 3'b000;
    for (int i = 0; i < N_CH; i++) begin
      elig_s[i] = (state_q == RUN) && bus.req[i] && (rem_q[i] != ZERO);
    end
  end

  rr_arb3 u_arb (
    .eligible (elig_s),
    .last     (last_q),
    .gnt      (gnt_s)
  );

  assign gidx_s = onehot_to_idx(gnt_s);

  // Address mux: granted channel's pointer, zero when nothing is granted.
  always_comb begin
    addr_s = ZERO;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_s[i]) addr_s = ptr_q[i];
      else          addr_s = addr_s;
    end
  end

  // Next-state logic for the run FSM and per-channel pointers/counters.
  always_comb begin
    state_d  = state_q;
    eos_d    = eos_q;
    last_d   = last_q;
    rvalid_d = gnt_s;
    done_d   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      ptr_d[i] = ptr_q[i];
      rem_d[i] = rem_q[i];
    end
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          last_d  = CH_B;
          for (int i = 0; i < N_CH; i++) begin
            ptr_d[i] = base_s[i];
            rem_d[i] = len_s[i];
            eos_d[i] = (len_s[i] == ZERO);
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < N_CH; i++) begin
          if (gnt_s[i]) begin
            ptr_d[i] = ptr_q[i] + ONE;
            rem_d[i] = rem_q[i] - ONE;
            eos_d[i] = eos_q[i] | (rem_q[i] == ONE);
          end else begin
            ptr_d[i] = ptr_q[i];
          end
        end
        if (gnt_s != 3'b000) last_d = gidx_s;
        else                 last_d = last_q;
        // Leave once every region is drained and no read is left in flight;
        // the final byte's rvalid is the cycle eos completes.
        if ((eos_q == 3'b111) && (rvalid_d == 3'b000)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      eos_q    <= 3'b000;
      rvalid_q <= 3'b000;
      last_q   <= CH_B;
      done_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        ptr_q[i] <= ZERO;
        rem_q[i] <= ZERO;
      end
    end else begin
      state_q  <= state_d;
      eos_q    <= eos_d;
      rvalid_q <= rvalid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      for (int i = 0; i < N_CH; i++) begin
        ptr_q[i] <= ptr_d[i];
        rem_q[i] <= rem_d[i];
      end
    end
  end

  assign bus.gnt      = gnt_s;
  assign bus.mem_rd   = |gnt_s;
  assign bus.mem_addr = addr_s;
  assign bus.rdata    = bus.mem_data;
  assign bus.rvalid   = rvalid_q;
  assign bus.eos      = eos_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_rle_fetch_arbiter.sv
// Directed, table-driven bench for rle_fetch_arbiter with a small
// synchronous memory model (data is a fixed function of the address).
module tb_rle_fetch_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rle_fetch_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  rle_fetch_arbiter #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        start;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [15:0] addr;
    logic [2:0]  rvalid;
    logic [2:0]  eos;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Synchronous read memory: one cycle latency.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= memf(bus.mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic st, input logic [2:0] rq, input logic [2:0] gn,
                             input logic [15:0] ad, input logic [2:0] rv, input logic [2:0] es,
                             input logic bz, input logic dn);
    vec_t r;
    r.start = st; r.req = rq; r.gnt = gn; r.addr = ad;
    r.rvalid = rv; r.eos = es; r.busy = bz; r.done = dn;
    return r;
  endfunction

  task automatic do_start(input logic [15:0] br, input logic [15:0] bg, input logic [15:0] bb,
                          input logic [15:0] lr, input logic [15:0] lg, input logic [15:0] lb,
                          input string name);
    bus.base_r = br; bus.base_g = bg; bus.base_b = bb;
    bus.len_r  = lr; bus.len_g  = lg; bus.len_b  = lb;
    bus.start  = 1'b1;
    bus.req    = 3'b111;
    @(negedge clk);
    check({name, ".idle_gnt"},  {29'd0, bus.gnt}, 32'd0);
    check({name, ".idle_busy"}, {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_table(input string name);
    logic [15:0] prev_addr;
    prev_addr = 16'h0000;
    for (int k = 0; k < tbl.size(); k++) begin
      bus.start = tbl[k].start;
      bus.req   = tbl[k].req;
      @(negedge clk);
      check($sformatf("%s[%0d].gnt", name, k),    {29'd0, bus.gnt},    {29'd0, tbl[k].gnt});
      check($sformatf("%s[%0d].mem_rd", name, k), {31'd0, bus.mem_rd}, {31'd0, |tbl[k].gnt});
      check($sformatf("%s[%0d].addr", name, k),   {16'd0, bus.mem_addr}, {16'd0, tbl[k].addr});
      check($sformatf("%s[%0d].rvalid", name, k), {29'd0, bus.rvalid}, {29'd0, tbl[k].rvalid});
      check($sformatf("%s[%0d].eos", name, k),    {29'd0, bus.eos},    {29'd0, tbl[k].eos});
      check($sformatf("%s[%0d].busy", name, k),   {31'd0, bus.busy},   {31'd0, tbl[k].busy});
      check($sformatf("%s[%0d].done", name, k),   {31'd0, bus.done},   {31'd0, tbl[k].done});
      if (tbl[k].rvalid != 3'b000)
        check($sformatf("%s[%0d].rdata", name, k), {24'd0, bus.rdata}, {24'd0, memf(prev_addr)});
      prev_addr = tbl[k].addr;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.req   = 3'b000;
    tbl.delete();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.req = 3'b000;
    bus.base_r = 16'h0; bus.base_g = 16'h0; bus.base_b = 16'h0;
    bus.len_r = 16'h0; bus.len_g = 16'h0; bus.len_b = 16'h0;
    bus.mem_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.gnt",    {29'd0, bus.gnt},      32'd0);
    check("rst.mem_rd", {31'd0, bus.mem_rd},   32'd0);
    check("rst.addr",   {16'd0, bus.mem_addr}, 32'd0);
    check("rst.rvalid", {29'd0, bus.rvalid},   32'd0);
    check("rst.eos",    {29'd0, bus.eos},      32'd0);
    check("rst.busy",   {31'd0, bus.busy},     32'd0);
    check("rst.done",   {31'd0, bus.done},     32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic round-robin over three 2-byte regions.
    do_start(16'h0000, 16'h0100, 16'h0200, 16'd2, 16'd2, 16'd2, "rr");
    tbl.push_back(v(0, 3'b111, 3'b001, 16'h0000, 3'b000, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b010, 16'h0100, 3'b001, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b100, 16'h0200, 3'b010, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b001, 16'h0001, 3'b100, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b010, 16'h0101, 3'b001, 3'b001, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b100, 16'h0201, 3'b010, 3'b011, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b100, 3'b111, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b000, 3'b111, 0, 1));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b000, 3'b111, 0, 0));
    run_table("rr");

    // Zero-length G region is skipped.
    do_start(16'h0010, 16'h0020, 16'h0030, 16'd1, 16'd0, 16'd1, "g0");
    tbl.push_back(v(0, 3'b111, 3'b001, 16'h0010, 3'b000, 3'b010, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b100, 16'h0030, 3'b001, 3'b011, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b100, 3'b111, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b000, 3'b111, 0, 1));
    run_table("g0");

    // Pointer wraps past the top of the address space.
    do_start(16'hFFFF, 16'h0000, 16'h0000, 16'd3, 16'd0, 16'd0, "wrap");
    tbl.push_back(v(0, 3'b001, 3'b001, 16'hFFFF, 3'b000, 3'b110, 1, 0));
    tbl.push_back(v(0, 3'b001, 3'b001, 16'h0000, 3'b001, 3'b110, 1, 0));
    tbl.push_back(v(0, 3'b001, 3'b001, 16'h0001, 3'b001, 3'b110, 1, 0));
    tbl.push_back(v(0, 3'b001, 3'b000, 16'h0000, 3'b001, 3'b111, 1, 0));
    tbl.push_back(v(0, 3'b001, 3'b000, 16'h0000, 3'b000, 3'b111, 0, 1));
    run_table("wrap");

    // G alone is granted back-to-back; then rotation continues after G.
    do_start(16'h0040, 16'h0050, 16'h0060, 16'd3, 16'd4, 16'd3, "rot");
    tbl.push_back(v(0, 3'b010, 3'b010, 16'h0050, 3'b000, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b010, 3'b010, 16'h0051, 3'b010, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b100, 16'h0060, 3'b010, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b001, 16'h0040, 3'b100, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b010, 16'h0052, 3'b001, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b100, 16'h0061, 3'b010, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b001, 16'h0041, 3'b100, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b010, 16'h0053, 3'b001, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b100, 16'h0062, 3'b010, 3'b010, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b001, 16'h0042, 3'b100, 3'b110, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b001, 3'b111, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b000, 3'b111, 0, 1));
    run_table("rot");

    // All-zero lengths: one RUN cycle, then done.
    do_start(16'h1234, 16'h2345, 16'h3456, 16'd0, 16'd0, 16'd0, "zero");
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b000, 3'b111, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b000, 3'b111, 0, 1));
    run_table("zero");

    // Reset in the grant cycle drops the in-flight read.
    do_start(16'h0080, 16'h0090, 16'h00A0, 16'd2, 16'd2, 16'd2, "rstm");
    bus.req = 3'b111;
    @(negedge clk);
    check("rstm.gnt_before", {29'd0, bus.gnt}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rstm.gnt",    {29'd0, bus.gnt},      32'd0);
    check("rstm.mem_rd", {31'd0, bus.mem_rd},   32'd0);
    check("rstm.addr",   {16'd0, bus.mem_addr}, 32'd0);
    check("rstm.busy",   {31'd0, bus.busy},     32'd0);
    check("rstm.eos",    {29'd0, bus.eos},      32'd0);
    @(posedge clk); #1;
    check("rstm.rvalid_held", {29'd0, bus.rvalid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rstm.rvalid_after", {29'd0, bus.rvalid}, 32'd0);
    check("rstm.gnt_idle",     {29'd0, bus.gnt},    32'd0);
    check("rstm.done",         {31'd0, bus.done},   32'd0);
    @(posedge clk); #1;
    do_start(16'h0080, 16'h0090, 16'h00A0, 16'd1, 16'd1, 16'd1, "rel");
    tbl.push_back(v(0, 3'b111, 3'b001, 16'h0080, 3'b000, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b010, 16'h0090, 3'b001, 3'b001, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b100, 16'h00A0, 3'b010, 3'b011, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b100, 3'b111, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b000, 3'b111, 0, 1));
    run_table("rel");

    // start during RUN with new config is ignored.
    do_start(16'h0300, 16'h0400, 16'h0500, 16'd2, 16'd2, 16'd2, "ign");
    bus.base_r = 16'h0700; bus.base_g = 16'h0800; bus.base_b = 16'h0900;
    bus.len_r  = 16'd5;    bus.len_g  = 16'd5;    bus.len_b  = 16'd5;
    tbl.push_back(v(0, 3'b111, 3'b001, 16'h0300, 3'b000, 3'b000, 1, 0));
    tbl.push_back(v(1, 3'b111, 3'b010, 16'h0400, 3'b001, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b100, 16'h0500, 3'b010, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b001, 16'h0301, 3'b100, 3'b000, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b010, 16'h0401, 3'b001, 3'b001, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b100, 16'h0501, 3'b010, 3'b011, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b100, 3'b111, 1, 0));
    tbl.push_back(v(0, 3'b111, 3'b000, 16'h0000, 3'b000, 3'b111, 0, 1));
    run_table("ign");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
